// File: rtl/ct2bit.sv
// Free-running WIDTH-bit binary up-counter with terminal-count, wrap pulse and Gray outputs.
// Reset is synchronous and active-high; out is undefined until the first reset edge.
module ct2bit #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             ck,
  input  logic             res,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] gray
);

  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] out_d, out_q;
  logic             wrap_d, wrap_q;
  logic             at_max;

  assign at_max = (out_q == {WIDTH{1'b1}});

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (res) begin
      out_d  = RstVal;
      wrap_d = 1'b0;
    end else begin
      out_d  = out_q + WIDTH'(1);
      // Pulse lines up with the 0 that follows the max value.
      wrap_d = at_max;
    end
  end

  always_ff @(posedge ck) begin
    out_q  <= out_d;
    wrap_q <= wrap_d;
  end

  assign out  = out_q;
  assign tc   = at_max;
  assign wrap = wrap_q;
  assign gray = out_q ^ (out_q >> 1);

endmodule

// File: tb/tb_ct2bit.sv
// Directed self-checking bench for ct2bit: default WIDTH=2 instance plus a WIDTH=3, RST_VAL=5 one.
module tb_ct2bit;

  logic       ck = 1'b0;
  logic       res;
  logic       res3;
  logic [1:0] out;
  logic       tc;
  logic       wrap;
  logic [1:0] gray;
  logic [2:0] out3;
  logic       tc3;
  logic       wrap3;
  logic [2:0] gray3;

  int tests  = 0;
  int failed = 0;

  ct2bit u_dut (
    .ck   (ck),
    .res  (res),
    .out  (out),
    .tc   (tc),
    .wrap (wrap),
    .gray (gray)
  );

  ct2bit #(
    .WIDTH   (3),
    .RST_VAL (5)
  ) u_dut3 (
    .ck   (ck),
    .res  (res3),
    .out  (out3),
    .tc   (tc3),
    .wrap (wrap3),
    .gray (gray3)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    res  = 1'b1;
    res3 = 1'b1;
    #1;

    // Reset held across two edges
    step();
    check("rst1_out", 32'(out), 32'd0);
    check("rst1_tc", 32'(tc), 32'd0);
    check("rst1_wrap", 32'(wrap), 32'd0);
    check("rst1_gray", 32'(gray), 32'd0);
    check("rst1_out3", 32'(out3), 32'd5);
    step();
    check("rst2_out", 32'(out), 32'd0);
    check("rst2_wrap", 32'(wrap), 32'd0);
    check("rst2_tc3", 32'(tc3), 32'd0);
    check("rst2_gray3", 32'(gray3), 32'd7);

    // Count through a full wrap
    res = 1'b0;
    step();
    check("cnt1_out", 32'(out), 32'd1);
    check("cnt1_gray", 32'(gray), 32'd1);
    check("cnt1_tc", 32'(tc), 32'd0);
    step();
    check("cnt2_out", 32'(out), 32'd2);
    check("cnt2_gray", 32'(gray), 32'd3);
    check("cnt2_tc", 32'(tc), 32'd0);
    step();
    check("cnt3_out", 32'(out), 32'd3);
    check("cnt3_tc", 32'(tc), 32'd1);
    check("cnt3_gray", 32'(gray), 32'd2);
    check("cnt3_wrap", 32'(wrap), 32'd0);
    step();
    check("cnt0_out", 32'(out), 32'd0);
    check("cnt0_wrap", 32'(wrap), 32'd1);
    check("cnt0_tc", 32'(tc), 32'd0);
    step();
    check("cnt1b_out", 32'(out), 32'd1);
    check("cnt1b_wrap", 32'(wrap), 32'd0);

    // Reset mid-count at 2
    step();
    check("mid_pre_out", 32'(out), 32'd2);
    res = 1'b1;
    step();
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_wrap", 32'(wrap), 32'd0);
    res = 1'b0;
    step();
    check("mid_resume_out", 32'(out), 32'd1);

    // Reset from the max value must not raise wrap
    step();
    step();
    check("max_pre_out", 32'(out), 32'd3);
    res = 1'b1;
    step();
    check("max_rst_out", 32'(out), 32'd0);
    check("max_rst_wrap", 32'(wrap), 32'd0);
    res = 1'b0;
    step();
    check("max_resume_out", 32'(out), 32'd1);

    // Reset pulse between edges has no effect
    #2 res = 1'b1;
    #2 res = 1'b0;
    check("glitch_out", 32'(out), 32'd1);
    step();
    check("glitch_next_out", 32'(out), 32'd2);

    // WIDTH=3, RST_VAL=5 instance
    res3 = 1'b0;
    step();
    check("w3_6_out", 32'(out3), 32'd6);
    check("w3_6_tc", 32'(tc3), 32'd0);
    step();
    check("w3_7_out", 32'(out3), 32'd7);
    check("w3_7_tc", 32'(tc3), 32'd1);
    check("w3_7_gray", 32'(gray3), 32'd4);
    check("w3_7_wrap", 32'(wrap3), 32'd0);
    step();
    check("w3_0_out", 32'(out3), 32'd0);
    check("w3_0_wrap", 32'(wrap3), 32'd1);
    check("w3_0_tc", 32'(tc3), 32'd0);
    step();
    check("w3_1_out", 32'(out3), 32'd1);
    check("w3_1_wrap", 32'(wrap3), 32'd0);
    res3 = 1'b1;
    step();
    check("w3_rst_out", 32'(out3), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
